defender_input_ctrl: RTL and testbench

// Input conditioning stage directly upstream of the defender core's btn_* inputs.

---
 rtl/defender_input_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_defender_input_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/defender_input_ctrl.sv
// Input conditioning for the defender core: PS/2 key decode into held key state,
// merged with the joystick word and a coin->start sequencer. All btn_* outputs are registered.
module defender_input_ctrl #(
  parameter int unsigned COIN_CYCLES = 2400000,
  parameter int unsigned GAP_CYCLES  = 2400000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  output logic        btn_up,
  output logic        btn_down,
  output logic        btn_thrust,
  output logic        btn_reverse,
  output logic        btn_fire,
  output logic        btn_smart_bomb,
  output logic        btn_hyperspace,
  output logic        btn_left_coin,
  output logic        btn_one_player,
  output logic        btn_two_players,
  output logic        btn_advance,
  output logic        btn_auto_up,
  output logic        btn_high_score_reset,
  output logic        seq_busy
);

  localparam int unsigned MAX_CYC = (COIN_CYCLES > GAP_CYCLES) ? COIN_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  // Per-key held-state bit positions
  localparam int unsigned K_UP     = 0;
  localparam int unsigned K_DOWN   = 1;
  localparam int unsigned K_THR_L  = 2;
  localparam int unsigned K_THR_R  = 3;
  localparam int unsigned K_BOMB   = 4;
  localparam int unsigned K_LSHIFT = 5;
  localparam int unsigned K_RSHIFT = 6;
  localparam int unsigned K_FIRE   = 7;
  localparam int unsigned K_F1     = 8;
  localparam int unsigned K_F2     = 9;
  localparam int unsigned K_HYPER  = 10;
  localparam int unsigned K_ADV    = 11;
  localparam int unsigned K_AUTO   = 12;
  localparam int unsigned K_HSR    = 13;
  localparam int unsigned K_START1 = 14;
  localparam int unsigned K_START2 = 15;
  localparam int unsigned K_COIN5  = 16;
  localparam int unsigned K_COIN6  = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COIN,
    S_GAP,
    S_START,
    S_HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           toggle_q;
  logic           armed_q;
  logic           joy8_q;
  logic [17:0]    keys_q, keys_d;
  logic [12:0]    out_q, out_d;
  logic           key_event;
  logic           seq_coin;
  logic           seq_start;
  logic           unused_joy;

  assign unused_joy = ^joy[15:9];
  assign key_event  = armed_q & (ps2_key[10] ^ toggle_q);

  always_comb begin
    keys_d = keys_q;
    if (key_event) begin
      // Extended-agnostic codes first; all exact codes have bit 8 clear.
      case (ps2_key[7:0])
        8'h75: keys_d[K_UP]    = ps2_key[9];
        8'h72: keys_d[K_DOWN]  = ps2_key[9];
        8'h6B: keys_d[K_THR_L] = ps2_key[9];
        8'h74: keys_d[K_THR_R] = ps2_key[9];
        8'h14: keys_d[K_BOMB]  = ps2_key[9];
        default: begin
          if (!ps2_key[8]) begin
            case (ps2_key[7:0])
              8'h12: keys_d[K_LSHIFT] = ps2_key[9];
              8'h59: keys_d[K_RSHIFT] = ps2_key[9];
              8'h29: keys_d[K_FIRE]   = ps2_key[9];
              8'h05: keys_d[K_F1]     = ps2_key[9];
              8'h06: keys_d[K_F2]     = ps2_key[9];
              8'h1D: keys_d[K_HYPER]  = ps2_key[9];
              8'h1C: keys_d[K_ADV]    = ps2_key[9];
              8'h3C: keys_d[K_AUTO]   = ps2_key[9];
              8'h33: keys_d[K_HSR]    = ps2_key[9];
              8'h16: keys_d[K_START1] = ps2_key[9];
              8'h1E: keys_d[K_START2] = ps2_key[9];
              8'h2E: keys_d[K_COIN5]  = ps2_key[9];
              8'h36: keys_d[K_COIN6]  = ps2_key[9];
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_coin  = 1'b0;
    seq_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (joy[8] && !joy8_q) begin
          state_d = S_COIN;
          cnt_d   = COIN_LOAD;
        end
      end
      S_COIN: begin
        seq_coin = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_START;
          cnt_d   = COIN_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_START: begin
        seq_start = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (!joy[8]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_d     = '0;
    out_d[12] = keys_q[K_UP] | joy[3];
    out_d[11] = keys_q[K_DOWN] | joy[2];
    out_d[10] = keys_q[K_THR_L] | keys_q[K_THR_R] | joy[0] | joy[1];
    out_d[9]  = keys_q[K_LSHIFT] | keys_q[K_RSHIFT] | joy[4];
    out_d[8]  = keys_q[K_FIRE] | joy[5];
    out_d[7]  = keys_q[K_BOMB] | joy[6];
    out_d[6]  = keys_q[K_HYPER] | joy[7];
    out_d[5]  = keys_q[K_COIN5] | keys_q[K_COIN6] | keys_q[K_F1] | keys_q[K_F2] | seq_coin;
    out_d[4]  = keys_q[K_F1] | keys_q[K_START1] | seq_start;
    out_d[3]  = keys_q[K_F2] | keys_q[K_START2];
    out_d[2]  = keys_q[K_ADV];
    out_d[1]  = keys_q[K_AUTO];
    out_d[0]  = keys_q[K_HSR];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      toggle_q <= 1'b0;
      armed_q  <= 1'b0;
      joy8_q   <= 1'b0;
      keys_q   <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      toggle_q <= ps2_key[10];
      armed_q  <= 1'b1;
      joy8_q   <= joy[8];
      keys_q   <= keys_d;
      out_q    <= out_d;
    end
  end

  assign btn_up               = out_q[12];
  assign btn_down             = out_q[11];
  assign btn_thrust           = out_q[10];
  assign btn_reverse          = out_q[9];
  assign btn_fire             = out_q[8];
  assign btn_smart_bomb       = out_q[7];
  assign btn_hyperspace       = out_q[6];
  assign btn_left_coin        = out_q[5];
  assign btn_one_player       = out_q[4];
  assign btn_two_players      = out_q[3];
  assign btn_advance          = out_q[2];
  assign btn_auto_up          = out_q[1];
  assign btn_high_score_reset = out_q[0];
  assign seq_busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_defender_input_ctrl.sv
// Scoreboard bench for defender_input_ctrl: stimulus queues expected output vectors
// tagged with the cycle they must appear; a negedge monitor pops and compares them.
module tb_defender_input_ctrl;

  localparam logic [13:0] M_BUSY = 14'h2000;
  localparam logic [13:0] M_UP   = 14'h1000;
  localparam logic [13:0] M_DOWN = 14'h0800;
  localparam logic [13:0] M_THR  = 14'h0400;
  localparam logic [13:0] M_REV  = 14'h0200;
  localparam logic [13:0] M_FIRE = 14'h0100;
  localparam logic [13:0] M_BOMB = 14'h0080;
  localparam logic [13:0] M_HYP  = 14'h0040;
  localparam logic [13:0] M_COIN = 14'h0020;
  localparam logic [13:0] M_P1   = 14'h0010;
  localparam logic [13:0] M_P2   = 14'h0008;
  localparam logic [13:0] M_ADV  = 14'h0004;
  localparam logic [13:0] M_HSR  = 14'h0001;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic btn_up, btn_down, btn_thrust, btn_reverse, btn_fire, btn_smart_bomb, btn_hyperspace;
  logic btn_left_coin, btn_one_player, btn_two_players, btn_advance, btn_auto_up;
  logic btn_high_score_reset, seq_busy;
  logic [13:0] dut_vec;

  typedef struct {
    int          cyc;
    logic [13:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t it;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  defender_input_ctrl #(.COIN_CYCLES(4), .GAP_CYCLES(3)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joy(joy),
    .btn_up(btn_up), .btn_down(btn_down), .btn_thrust(btn_thrust),
    .btn_reverse(btn_reverse), .btn_fire(btn_fire), .btn_smart_bomb(btn_smart_bomb),
    .btn_hyperspace(btn_hyperspace), .btn_left_coin(btn_left_coin),
    .btn_one_player(btn_one_player), .btn_two_players(btn_two_players),
    .btn_advance(btn_advance), .btn_auto_up(btn_auto_up),
    .btn_high_score_reset(btn_high_score_reset), .seq_busy(seq_busy)
  );

  assign dut_vec = {seq_busy, btn_up, btn_down, btn_thrust, btn_reverse, btn_fire,
                    btn_smart_bomb, btn_hyperspace, btn_left_coin, btn_one_player,
                    btn_two_players, btn_advance, btn_auto_up, btn_high_score_reset};

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      n_tests++;
      if (it.cyc != cyc || dut_vec !== it.exp) begin
        n_fail++;
        $display("FAIL %s @cyc %0d (due %0d): got %b expected %b", it.name, cyc, it.cyc, dut_vec, it.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic exp_at(input int at, input logic [13:0] v, input string nm);
    sb.push_back('{at, v, nm});
  endtask

  // Expected vector k cycles after the joy[8] press when the press lasts `hold` cycles
  function automatic logic [13:0] seq_vec(input int k, input int hold);
    logic [13:0] v;
    v = '0;
    if (k >= 1 && k <= hold) v |= M_BUSY;
    if (k >= 2 && k <= 5)    v |= M_COIN;
    if (k >= 9 && k <= 12)   v |= M_P1;
    return v;
  endfunction

  int s;

  initial begin
    reset_n = 1'b0;
    ps2_key = 11'h400;
    joy     = '0;
    tick(3);
    exp_at(cyc, '0, "reset_state");
    tick(1);

    // (1) no spurious event after reset release with ps2_key[10]=1
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) exp_at(cyc + i, '0, "no_spurious");
    tick(10);

    // (2) up key press / release, 2-edge latency
    ps2_key = 11'h275;
    exp_at(cyc + 1, '0, "up_latency");
    exp_at(cyc + 2, M_UP, "up_press");
    tick(3);
    ps2_key = 11'h475;
    exp_at(cyc + 1, M_UP, "up_hold");
    exp_at(cyc + 2, '0, "up_release");
    tick(3);

    // (3) two thrust keys OR'd
    ps2_key = 11'h36B;
    exp_at(cyc + 2, M_THR, "thrust_l_press");
    tick(1);
    ps2_key = 11'h774;
    tick(1);
    ps2_key = 11'h16B;
    exp_at(cyc + 2, M_THR, "thrust_held_a");
    exp_at(cyc + 3, M_THR, "thrust_held_b");
    tick(4);
    ps2_key = 11'h574;
    exp_at(cyc + 2, '0, "thrust_release");
    tick(3);

    // (6a) unknown code ignored
    ps2_key = 11'h2AA;
    for (int i = 1; i <= 3; i++) exp_at(cyc + i, '0, "unknown_code");
    tick(3);

    // (6b) consecutive-cycle events F1 then F2
    ps2_key = 11'h605;
    exp_at(cyc + 2, M_COIN | M_P1, "f1_press");
    tick(1);
    ps2_key = 11'h206;
    exp_at(cyc + 2, M_COIN | M_P1 | M_P2, "f1_f2_press");
    tick(3);
    ps2_key = 11'h405;
    tick(1);
    ps2_key = 11'h006;
    exp_at(cyc + 2, '0, "f1_f2_release");
    tick(3);

    // Service keys; extended 13C must not alias auto_up
    ps2_key = 11'h61C;
    exp_at(cyc + 2, M_ADV, "advance");
    tick(1);
    ps2_key = 11'h33C;
    tick(1);
    ps2_key = 11'h633;
    exp_at(cyc + 2, M_ADV | M_HSR, "adv_hsr_no_ext_auto");
    tick(3);
    ps2_key = 11'h01C;
    tick(1);
    ps2_key = 11'h433;
    exp_at(cyc + 2, '0, "service_release");
    tick(3);

    // Extended ctrl still maps to smart bomb
    ps2_key = 11'h314;
    exp_at(cyc + 2, M_BOMB, "ext_ctrl_bomb");
    tick(3);
    ps2_key = 11'h514;
    exp_at(cyc + 2, '0, "bomb_release");
    tick(3);

    // Joystick merge, 1-edge latency
    joy = 16'h0001;
    exp_at(cyc + 1, M_THR, "joy_right");
    tick(1);
    joy = 16'h00F4;
    exp_at(cyc + 1, M_DOWN | M_REV | M_FIRE | M_BOMB | M_HYP, "joy_misc");
    tick(1);
    joy = 16'h0008;
    exp_at(cyc + 1, M_UP, "joy_up");
    tick(1);
    joy = '0;
    exp_at(cyc + 1, '0, "joy_clear");
    tick(3);

    // (4) single coin->start sequence, joy[8] held 20 cycles
    s = cyc;
    joy = 16'h0100;
    for (int k = 0; k <= 20; k++) exp_at(s + k, seq_vec(k, 20), "seq_run");
    tick(20);
    joy = '0;
    for (int k = 21; k <= 24; k++) exp_at(s + k, seq_vec(k, 20), "seq_done");
    tick(6);

    // (5) reset during GAP, then a fresh press restarts from COIN
    s = cyc;
    joy = 16'h0100;
    for (int k = 0; k <= 5; k++) exp_at(s + k, seq_vec(k, 20), "seq_pre_reset");
    tick(6);
    reset_n = 1'b0;
    joy = '0;
    for (int k = 6; k <= 10; k++) exp_at(s + k, '0, "reset_in_gap");
    tick(1);
    reset_n = 1'b1;
    tick(3);
    s = cyc;
    joy = 16'h0100;
    for (int k = 0; k <= 14; k++) exp_at(s + k, seq_vec(k, 14), "seq_restart");
    tick(14);
    joy = '0;
    for (int k = 15; k <= 17; k++) exp_at(s + k, seq_vec(k, 14), "seq_restart_done");
    tick(5);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
